instr_fetch_unit: RTL and testbench



---
 rtl/rv_core_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared RISC-V core definitions: fetch PC width, RV32I-subset base
// opcodes accepted by the fetch stage, and the fetch control states.
package rv_core_pkg;

   localparam int PC_W = 11;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_L    = 7'b0000011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   typedef enum logic {
      FS_RUN  = 1'b0,
      FS_HALT = 1'b1
   } fetch_state_e;

   // True when the opcode belongs to the subset the core executes.
   function automatic logic is_legal_opcode(input logic [6:0] opcode);
      logic legal;
      case (opcode)
         OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_JALR: legal = 1'b1;
         default:                                       legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} fetch results. The head entry is
// read combinationally; flush empties the FIFO and beats push and pop.
module fetch_fifo
   import rv_core_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic            CLOCK_50,
   input  logic            rst,
   input  logic            flush,
   input  logic            push,
   input  logic [PC_W-1:0] push_pc,
   input  logic [31:0]     push_instr,
   input  logic            pop,
   output logic [PC_W-1:0] head_pc,
   output logic [31:0]     head_instr,
   output logic [CW-1:0]   count
);

   logic [PC_W-1:0] mem_pc    [DEPTH];
   logic [31:0]     mem_instr [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   // Never pop an empty FIFO; a push into a full FIFO is only legal alongside a pop.
   always_comb begin
      do_pop  = pop && (count != '0);
      do_push = push && ((count != CW'(DEPTH)) || do_pop);
   end

   // Pointers and occupancy; flush wins over everything else.
   always_ff @(posedge CLOCK_50) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage, cleared on reset so the head reads zero until filled.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i]    <= '0;
            mem_instr[i] <= '0;
         end
      end else if (do_push && !flush) begin
         mem_pc[wr_ptr]    <= push_pc;
         mem_instr[wr_ptr] <= push_instr;
      end
   end

   // Head entry is visible the cycle after it is written.
   always_comb begin
      head_pc    = mem_pc[rd_ptr];
      head_instr = mem_instr[rd_ptr];
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, drives the synchronous instruction ROM,
// tracks in-flight reads, buffers results and hands them to the core.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FS_RUN  | fetching normally, redirects accepted
// FS_HALT | illegal opcode reached the head; everything frozen until rst
module instr_fetch_unit
   import rv_core_pkg::*;
#(
   parameter int              ROM_AW   = 8,
   parameter int              ROM_LAT  = 1,
   parameter int              DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              CLOCK_50,
   input  logic              rst,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_q,
   output logic [31:0]       instr,
   output logic [PC_W-1:0]   instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              halted
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(DEPTH + ROM_LAT + 2) + 1;
   localparam int TL = ROM_LAT - 1;

   fetch_state_e    state_q;
   fetch_state_e    state_d;

   logic [PC_W-1:0] fetch_pc;
   logic            epoch_q;

   logic            pipe_v  [ROM_LAT];
   logic [PC_W-1:0] pipe_pc [ROM_LAT];
   logic            pipe_ep [ROM_LAT];

   logic [CW-1:0]   fifo_count;
   logic [PC_W-1:0] head_pc;
   logic [31:0]     head_instr;
   logic [PC_W-1:0] pc_hold;
   logic [31:0]     instr_hold;

   logic            fifo_has;
   logic            pop;
   logic            push;
   logic            issue;
   logic            redirect_take;
   logic [SW-1:0]   inflight;
   logic [SW-1:0]   occupancy;
   logic            unused_rpc_bits;

   assign unused_rpc_bits = ^redirect_pc[1:0];

   assign rom_addr = fetch_pc[ROM_AW+1:2];

   // Credit check counts buffered plus in-flight words, including stale ones
   // still draining after a redirect, so the FIFO can never overflow.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < ROM_LAT; i++) begin
         inflight = inflight + SW'(pipe_v[i]);
      end
      occupancy     = SW'(fifo_count) + inflight;
      fifo_has      = (fifo_count != '0);
      instr_valid   = fifo_has && !halted;
      pop           = instr_valid && instr_ready;
      redirect_take = redirect && !halted;
      issue         = (occupancy < (SW'(DEPTH) + SW'(pop))) && !halted && !redirect;
      push          = pipe_v[TL] && (pipe_ep[TL] == epoch_q) && !halted;
   end

   // Fetch PC and epoch: a redirect restarts fetch at the word-aligned target.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         epoch_q  <= 1'b0;
      end else if (redirect_take) begin
         fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
         epoch_q  <= ~epoch_q;
      end else if (issue) begin
         fetch_pc <= fetch_pc + PC_W'(4);
      end
   end

   // In-flight shift register aligned with the ROM read latency.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         for (int i = 0; i < ROM_LAT; i++) begin
            pipe_v[i]  <= 1'b0;
            pipe_pc[i] <= '0;
            pipe_ep[i] <= 1'b0;
         end
      end else begin
         pipe_v[0]  <= issue;
         pipe_pc[0] <= fetch_pc;
         pipe_ep[0] <= epoch_q;
         for (int i = 1; i < ROM_LAT; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_pc[i] <= pipe_pc[i-1];
            pipe_ep[i] <= pipe_ep[i-1];
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLOCK_50   (CLOCK_50),
      .rst        (rst),
      .flush      (redirect_take),
      .push       (push),
      .push_pc    (pipe_pc[TL]),
      .push_instr (rom_q),
      .pop        (pop),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .count      (fifo_count)
   );

   // Remember the last presented head so the outputs hold while the FIFO is empty.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         pc_hold    <= '0;
         instr_hold <= '0;
      end else if (fifo_has) begin
         pc_hold    <= head_pc;
         instr_hold <= head_instr;
      end
   end

   // Head presentation: live FIFO head when occupied, otherwise the held copy.
   always_comb begin
      instr    = fifo_has ? head_instr : instr_hold;
      instr_pc = fifo_has ? head_pc    : pc_hold;
   end

   // Halt state register.
   always_ff @(posedge CLOCK_50) begin
      if (rst) state_q <= FS_RUN;
      else     state_q <= state_d;
   end

   // Halt once an illegal opcode sits at the head; only reset leaves FS_HALT.
   always_comb begin
      state_d = state_q;
      halted  = 1'b0;
      case (state_q)
         FS_RUN: begin
            if (fifo_has && !is_legal_opcode(head_instr[6:0])) state_d = FS_HALT;
         end
         FS_HALT: begin
            halted = 1'b1;
         end
         default: state_d = FS_RUN;
      endcase
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a registered one-cycle ROM model.
// Inputs are driven and outputs sampled at the falling edge.
module tb_instr_fetch_unit;
   import rv_core_pkg::*;

   logic        CLOCK_50 = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rom_addr;
   logic [31:0] rom_q = '0;
   logic [31:0] instr;
   logic [10:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic        redirect = 1'b0;
   logic [10:0] redirect_pc = '0;
   logic        halted;

   logic [31:0] rom [256];
   int n_vec = 0;
   int n_err = 0;

   instr_fetch_unit #(
      .ROM_AW   (8),
      .ROM_LAT  (1),
      .DEPTH    (2),
      .RESET_PC (11'h000)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .rst         (rst),
      .rom_addr    (rom_addr),
      .rom_q       (rom_q),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halted      (halted)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) rom_q <= rom[rom_addr];

   // addi x1, x1, <word index>: legal I-type with a distinct immediate per word
   function automatic logic [31:0] rom_word(input logic [7:0] a);
      return {4'h0, a, 5'd1, 3'd0, 5'd1, 7'h13};
   endfunction

   task automatic step();
      @(negedge CLOCK_50);
   endtask

   task automatic reset_and_release();
      rst = 1'b1;
      redirect = 1'b0;
      instr_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_vec++; if (rom_addr !== 8'h00) begin n_err++; $display("FAIL reset_rom_addr got %h want 00", rom_addr); end
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", instr_valid); end
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
      n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", instr); end
      n_vec++; if (instr_pc !== 11'h000) begin n_err++; $display("FAIL reset_pc got %h want 000", instr_pc); end
      rst = 1'b0;
   endtask

   // Cycles 0..3 after release: rom_addr equals the cycle number, first word at cycle 2.
   task automatic test_stream();
      logic [10:0] exp_pc;
      for (int k = 0; k < 4; k++) begin
         n_vec++; if (rom_addr !== 8'(k)) begin n_err++; $display("FAIL stream_rom_addr c%0d got %h want %h", k, rom_addr, 8'(k)); end
         if (k < 2) begin
            n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_startup_valid c%0d got %b want 0", k, instr_valid); end
         end else begin
            exp_pc = 11'((k - 2) * 4);
            n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid c%0d got %b want 1", k, instr_valid); end
            n_vec++; if (instr_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc c%0d got %h want %h", k, instr_pc, exp_pc); end
            n_vec++; if (instr !== rom_word(exp_pc[9:2])) begin n_err++; $display("FAIL stream_instr c%0d got %h want %h", k, instr, rom_word(exp_pc[9:2])); end
         end
         step();
      end
   endtask

   // Cycles 4..8 stalled on head 0x008, then released through 0x010.
   task automatic test_backpressure();
      logic [10:0] exp_pc;
      for (int k = 0; k < 5; k++) begin
         n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid s%0d got %b want 1", k, instr_valid); end
         n_vec++; if (instr_pc !== 11'h008) begin n_err++; $display("FAIL bp_hold_pc s%0d got %h want 008", k, instr_pc); end
         n_vec++; if (instr !== rom_word(8'd2)) begin n_err++; $display("FAIL bp_hold_instr s%0d got %h want %h", k, instr, rom_word(8'd2)); end
         n_vec++; if (rom_addr !== 8'h04) begin n_err++; $display("FAIL bp_rom_stall s%0d got %h want 04", k, rom_addr); end
         if (k == 0) instr_ready = 1'b0;
         step();
      end
      instr_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         exp_pc = 11'(8 + 4 * j);
         n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL bp_release_valid r%0d got %b want 1", j, instr_valid); end
         n_vec++; if (instr_pc !== exp_pc) begin n_err++; $display("FAIL bp_release_pc r%0d got %h want %h", j, instr_pc, exp_pc); end
         if (j < 2) step();
      end
   endtask

   // Redirect while 0x010 is at the head and 0x014 is in flight.
   task automatic test_redirect();
      redirect = 1'b1;
      redirect_pc = 11'h043;
      step();
      redirect = 1'b0;
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_gap1 got %b want 0", instr_valid); end
      n_vec++; if (rom_addr !== 8'h10) begin n_err++; $display("FAIL redir_rom_addr got %h want 10", rom_addr); end
      step();
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_gap2 got %b want 0", instr_valid); end
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 11'h040) begin n_err++; $display("FAIL redir_first got v=%b pc=%h want v=1 pc=040", instr_valid, instr_pc); end
      n_vec++; if (instr !== rom_word(8'h10)) begin n_err++; $display("FAIL redir_first_instr got %h want %h", instr, rom_word(8'h10)); end
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 11'h044) begin n_err++; $display("FAIL redir_second got v=%b pc=%h want v=1 pc=044", instr_valid, instr_pc); end
   endtask

   // Redirect coinciding with a pop of 0x008 while 0x00C is in flight.
   task automatic test_redirect_pop();
      reset_and_release();
      for (int k = 0; k < 4; k++) step();
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 11'h008) begin n_err++; $display("FAIL rp_setup got v=%b pc=%h want v=1 pc=008", instr_valid, instr_pc); end
      redirect = 1'b1;
      redirect_pc = 11'h080;
      step();
      redirect = 1'b0;
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rp_gap1 got v=%b pc=%h want v=0", instr_valid, instr_pc); end
      step();
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rp_gap2 got v=%b pc=%h want v=0", instr_valid, instr_pc); end
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 11'h080) begin n_err++; $display("FAIL rp_target got v=%b pc=%h want v=1 pc=080", instr_valid, instr_pc); end
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 11'h084) begin n_err++; $display("FAIL rp_next got v=%b pc=%h want v=1 pc=084", instr_valid, instr_pc); end
   endtask

   // Redirect to 0x7F8 (low bits dropped) and follow the PC across the wrap.
   task automatic test_wrap();
      redirect = 1'b1;
      redirect_pc = 11'h7F9;
      step();
      redirect = 1'b0;
      n_vec++; if (rom_addr !== 8'hFE) begin n_err++; $display("FAIL wrap_addr_fe got %h want fe", rom_addr); end
      step();
      n_vec++; if (rom_addr !== 8'hFF) begin n_err++; $display("FAIL wrap_addr_ff got %h want ff", rom_addr); end
      step();
      n_vec++; if (rom_addr !== 8'h00) begin n_err++; $display("FAIL wrap_addr_00 got %h want 00", rom_addr); end
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 11'h7F8) begin n_err++; $display("FAIL wrap_pc_7f8 got v=%b pc=%h want v=1 pc=7f8", instr_valid, instr_pc); end
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 11'h7FC) begin n_err++; $display("FAIL wrap_pc_7fc got v=%b pc=%h want v=1 pc=7fc", instr_valid, instr_pc); end
      n_vec++; if (instr !== rom_word(8'hFF)) begin n_err++; $display("FAIL wrap_instr_7fc got %h want %h", instr, rom_word(8'hFF)); end
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 11'h000) begin n_err++; $display("FAIL wrap_pc_000 got v=%b pc=%h want v=1 pc=000", instr_valid, instr_pc); end
      n_vec++; if (instr !== rom_word(8'h00)) begin n_err++; $display("FAIL wrap_instr_000 got %h want %h", instr, rom_word(8'h00)); end
   endtask

   // Illegal word at 0x00C halts fetch; redirect is ignored; reset recovers.
   task automatic test_halt();
      rom[3] = 32'h0000_0000;
      reset_and_release();
      for (int k = 0; k < 5; k++) step();
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 11'h00C) begin n_err++; $display("FAIL halt_head got v=%b pc=%h want v=1 pc=00c", instr_valid, instr_pc); end
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_early got %b want 0", halted); end
      instr_ready = 1'b0;
      step();
      n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set got %b want 1", halted); end
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid got %b want 0", instr_valid); end
      n_vec++; if (rom_addr !== 8'h05) begin n_err++; $display("FAIL halt_rom_addr got %h want 05", rom_addr); end
      redirect = 1'b1;
      redirect_pc = 11'h100;
      instr_ready = 1'b1;
      step();
      redirect = 1'b0;
      n_vec++; if (rom_addr !== 8'h05) begin n_err++; $display("FAIL halt_redir_ignored got %h want 05", rom_addr); end
      n_vec++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_sticky got h=%b v=%b want h=1 v=0", halted, instr_valid); end
      n_vec++; if (instr_pc !== 11'h00C || instr !== 32'h0) begin n_err++; $display("FAIL halt_frozen got pc=%h instr=%h want pc=00c instr=0", instr_pc, instr); end
      rst = 1'b1;
      step();
      n_vec++; if (halted !== 1'b0 || rom_addr !== 8'h00 || instr_valid !== 1'b0 || instr_pc !== 11'h000) begin n_err++; $display("FAIL halt_rst got h=%b a=%h v=%b pc=%h want h=0 a=00 v=0 pc=000", halted, rom_addr, instr_valid, instr_pc); end
      rom[3] = rom_word(8'd3);
      rst = 1'b0;
      step();
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 11'h000) begin n_err++; $display("FAIL halt_restart got v=%b pc=%h want v=1 pc=000", instr_valid, instr_pc); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d vectors", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = rom_word(8'(i));
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_pop();
      test_wrap();
      test_halt();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
